// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer. Latency is one cycle from input to output.
// in_ready comes from a register and drops only when both entries are held; hazard_stall blocks output transfer.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              hazard_stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic                in_fire;
  logic                out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~hazard_stall;

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic; flush overrides every normal transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (in_fire) state_d = S_ONE;
      S_ONE: begin
        if (in_fire && !out_fire)      state_d = S_FULL;
        else if (!in_fire && out_fire) state_d = S_EMPTY;
      end
      S_FULL:  if (out_fire) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  // Payload movement. Entry contents are don't-care once flushed, so flush
  // does not need to touch them.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    unique case (state_q)
      S_EMPTY: if (in_fire) main_d = in_data;
      S_ONE: begin
        if (in_fire && out_fire) main_d = in_data;
        else if (in_fire)        skid_d = in_data;
      end
      S_FULL:  if (out_fire) main_d = skid_q;
      default: ;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_fire && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Handshake outputs depend on the state register alone.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    unique case (state_q)
      S_EMPTY: ;
      S_ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      S_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  assign out_data  = out_valid ? main_q : BUBBLE;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a queue-based reference model serves as the scoreboard.
// Directed scenarios run first, followed by a randomized phase.
module tb_pipe_stage_skid;

  localparam int DATA_W  = 64;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic              clk;
  logic              resetn;
  logic              flush;
  logic              hazard_stall;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_skid #(.DATA_W(DATA_W), .BUBBLE('0), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .hazard_stall (hazard_stall),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] exp_q[$];
  int                m_cnt;
  int                n_chk;
  int                n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input logic rn, input logic fl, input logic hz, input logic iv,
                       input logic [DATA_W-1:0] id, input logic orr);
    logic m_ov, m_ir, m_of, m_if;
    resetn       = rn;
    flush        = fl;
    hazard_stall = hz;
    in_valid     = iv;
    in_data      = id;
    out_ready    = orr;
    @(negedge clk);
    m_ov = exp_q.size() > 0;
    m_ir = exp_q.size() < 2;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
    chk("in_ready",  {63'd0, in_ready},  {63'd0, m_ir});
    chk("occupancy", {62'd0, occupancy}, 64'(exp_q.size()));
    chk("stall_cnt", {60'd0, stall_cnt}, 64'(m_cnt));
    chk("out_data",  out_data, m_ov ? exp_q[0] : 64'd0);
    m_of = m_ov & orr & ~hz;
    m_if = iv & m_ir;
    if (!rn) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (m_ov && !m_of && m_cnt < CNT_MAX) m_cnt++;
      if (m_of) void'(exp_q.pop_front());
      if (fl) exp_q.delete();
      else if (m_if) exp_q.push_back(id);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic orr);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, orr);
  endtask

  initial begin
    logic [DATA_W-1:0] seq;
    n_chk = 0;
    n_err = 0;
    m_cnt = 0;
    resetn = 1'b0; flush = 1'b0; hazard_stall = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single transfer from reset
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 64'h00400000_20080001, 1'b1);
    chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_out_data",  out_data, 64'h00400000_20080001);
    chk("t1_occupancy", {62'd0, occupancy}, 64'd1);
    chk("t1_in_ready",  {63'd0, in_ready}, 64'd1);
    idle(1'b1);

    // Back-to-back stream
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 64'hA0 + 64'(i), 1'b1);
    idle(1'b1);
    chk("t2_stall_cnt", {60'd0, stall_cnt}, 64'd0);

    // Hazard fills the skid entry; C waits upstream
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 64'h0A, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 64'h0B, 1'b1);
    chk("t3_in_ready_full", {63'd0, in_ready}, 64'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 64'h0C, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 64'h0C, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 64'h0C, 1'b1);
    idle(1'b1);
    chk("t3_stall_cnt", {60'd0, stall_cnt}, 64'd2);

    // Flush while FULL drops B and the incoming C
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 64'h1A, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 64'h1B, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 64'h1C, 1'b1);
    chk("t4_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t4_out_data",  out_data, 64'd0);
    chk("t4_occupancy", {62'd0, occupancy}, 64'd0);
    chk("t4_stall_cnt", {60'd0, stall_cnt}, 64'd3);
    idle(1'b1);
    idle(1'b1);

    // Saturating stall counter
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 64'h2A, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    chk("t6_stall_sat", {60'd0, stall_cnt}, 64'd15);
    idle(1'b1);

    // Reset while FULL with out_ready high
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 64'h3A, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 64'h3B, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    chk("t5_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_in_ready",  {63'd0, in_ready}, 64'd1);
    chk("t5_occupancy", {62'd0, occupancy}, 64'd0);
    chk("t5_out_data",  out_data, 64'd0);
    chk("t5_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Randomized traffic with occasional flush, hazard and reset
    seq = 64'hC000_0000_0000_0000;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0),
            seq,
            ($urandom_range(0, 3) != 0));
      seq = seq + 64'd1;
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
